// File: rtl/game_timer_if.sv
// ---------------------------------------------------------------------------
// game_timer_if
//   Signal bundle between the game control block (master) and the round
//   engine game_timer (slave).
//
//   Control -> timer : state[1:0], Mode, value[6:0], word_done, key_err
//   Timer -> control : finish, secs[6:0], words[6:0], errs[7:0], wpm[7:0]
// ---------------------------------------------------------------------------
interface game_timer_if;
    logic [1:0] state;
    logic       Mode;
    logic [6:0] value;
    logic       word_done;
    logic       key_err;

    logic       finish;
    logic [6:0] secs;
    logic [6:0] words;
    logic [7:0] errs;
    logic [7:0] wpm;

    modport master (
        output state, Mode, value, word_done, key_err,
        input  finish, secs, words, errs, wpm
    );

    modport slave (
        input  state, Mode, value, word_done, key_err,
        output finish, secs, words, errs, wpm
    );
endinterface

// File: rtl/game_timer.sv
// ---------------------------------------------------------------------------
// game_timer
//   Round engine for the typing game. While the control FSM sits in INGAME
//   (state == 2) it counts game seconds, completed words and wrong
//   keystrokes, and raises finish when the round limit is reached
//   (time mode: seconds run out; word mode: word target reached).
//
//   Parameters:
//     TICKS_PER_SEC : clk cycles per game second (>= 2)
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : game_timer_if.slave
//            in  state, Mode, value, word_done, key_err
//            out finish, secs, words, errs, wpm
//
//   Build option:
//     GAME_TIMER_WPM_EN : when defined, words-per-minute is computed on the
//                         round-complete edge; otherwise wpm reads 0.
// ---------------------------------------------------------------------------
module game_timer #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    game_timer_if.slave bus
);

    localparam int unsigned   PW         = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t          fsm_q, fsm_n;
    logic [PW-1:0] presc_q, presc_n;
    logic          mode_q, mode_n;
    logic [6:0]    value_q, value_n;
    logic [6:0]    secs_q, secs_n;
    logic [6:0]    words_q, words_n;
    logic [7:0]    errs_q, errs_n;
    logic          finish_q, finish_n;

    logic          in_game;
    logic          tick;
    logic [6:0]    secs_upd;
    logic [6:0]    words_upd;
    logic [7:0]    errs_upd;
    logic          limit_hit;

    assign in_game = (bus.state == 2'd2);

    // Counter values as they would be after this cycle's events in RUN.
    // Both the completion test and the WPM computation use these so that
    // the limiting tick/word is reflected on the same edge finish rises.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        secs_upd  = secs_q;
        words_upd = words_q;
        errs_upd  = errs_q;

        if (tick) begin
            if (mode_q) begin
                if (secs_q != 7'd127) secs_upd = secs_q + 7'd1;
            end else begin
                if (secs_q != '0) secs_upd = secs_q - 7'd1;
            end
        end
        if (bus.word_done && (words_q != 7'd127)) words_upd = words_q + 7'd1;
        if (bus.key_err && (errs_q != 8'd255))    errs_upd  = errs_q + 8'd1;

        limit_hit = mode_q ? (words_upd >= value_q) : (secs_upd == '0);
    end

    always_comb begin
        fsm_n    = fsm_q;
        presc_n  = presc_q;
        mode_n   = mode_q;
        value_n  = value_q;
        secs_n   = secs_q;
        words_n  = words_q;
        errs_n   = errs_q;
        finish_n = finish_q;

        case (fsm_q)
            IDLE: begin
                finish_n = 1'b0;
                if (in_game) begin
                    fsm_n   = RUN;
                    mode_n  = bus.Mode;
                    value_n = bus.value;
                    secs_n  = bus.Mode ? '0 : bus.value;
                    words_n = '0;
                    errs_n  = '0;
                    presc_n = '0;
                end
            end

            RUN: begin
                if (!in_game) begin
                    // Abort: counters keep their values for display.
                    fsm_n    = IDLE;
                    finish_n = 1'b0;
                end else begin
                    presc_n = tick ? '0 : presc_q + PW'(1);
                    secs_n  = secs_upd;
                    words_n = words_upd;
                    errs_n  = errs_upd;
                    if (limit_hit) begin
                        fsm_n    = DONE;
                        finish_n = 1'b1;
                    end
                end
            end

            DONE: begin
                if (bus.state == 2'd0) begin
                    fsm_n    = IDLE;
                    finish_n = 1'b0;
                end
            end

            default: begin
                fsm_n    = IDLE;
                finish_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= IDLE;
            presc_q  <= '0;
            mode_q   <= 1'b0;
            value_q  <= '0;
            secs_q   <= '0;
            words_q  <= '0;
            errs_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_n;
            presc_q  <= presc_n;
            mode_q   <= mode_n;
            value_q  <= value_n;
            secs_q   <= secs_n;
            words_q  <= words_n;
            errs_q   <= errs_n;
            finish_q <= finish_n;
        end
    end

    assign bus.finish = finish_q;
    assign bus.secs   = secs_q;
    assign bus.words  = words_q;
    assign bus.errs   = errs_q;

`ifdef GAME_TIMER_WPM_EN
    logic [7:0]  wpm_q, wpm_n;
    logic [6:0]  elapsed;
    logic [12:0] words_x60;
    logic [12:0] quotient;

    // 127 words * 60 = 7620 fits in 13 bits.
    always_comb begin
        elapsed = mode_q ? secs_upd : value_q;
        if (elapsed == '0) elapsed = 7'd1;
        words_x60 = 13'(words_upd) * 13'd60;
        quotient  = words_x60 / 13'(elapsed);
        wpm_n     = wpm_q;
        if ((fsm_q == RUN) && in_game && limit_hit)
            wpm_n = (quotient > 13'd255) ? 8'd255 : quotient[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wpm_q <= '0;
        else     wpm_q <= wpm_n;
    end

    assign bus.wpm = wpm_q;
`else
    assign bus.wpm = '0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// ---------------------------------------------------------------------------
// tb_game_timer
//   Self-checking bench for game_timer with TICKS_PER_SEC = 4. Expected
//   output snapshots are pushed to a queue as stimulus is driven and popped
//   for comparison once the DUT has clocked that stimulus in.
// ---------------------------------------------------------------------------
module tb_game_timer;

`ifdef GAME_TIMER_WPM_EN
    localparam bit WPM_EN = 1'b1;
`else
    localparam bit WPM_EN = 1'b0;
`endif

    typedef struct packed {
        logic       finish;
        logic [6:0] secs;
        logic [6:0] words;
        logic [7:0] errs;
        logic [7:0] wpm;
    } snap_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    snap_t exp_q[$];
    logic [7:0] wpm_prev;

    game_timer_if gif ();

    game_timer #(
        .TICKS_PER_SEC(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t mk(input logic f, input int s, input int w, input int e, input int p);
        snap_t r;
        r.finish = f;
        r.secs   = 7'(s);
        r.words  = 7'(w);
        r.errs   = 8'(e);
        r.wpm    = 8'(p);
        return r;
    endfunction

    function automatic snap_t sample();
        snap_t r;
        r = {gif.finish, gif.secs, gif.words, gif.errs, gif.wpm};
        return r;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("fin=%0b secs=%0d words=%0d errs=%0d wpm=%0d",
                         s.finish, s.secs, s.words, s.errs, s.wpm);
    endfunction

    function automatic int time_secs(input int start, input int k);
        return start - (k / 4);
    endfunction

    task automatic drive_idle();
        gif.state     = 2'd0;
        gif.Mode      = 1'b0;
        gif.value     = 7'd0;
        gif.word_done = 1'b0;
        gif.key_err   = 1'b0;
    endtask

    // Power-on reset, then reset asserted in the middle of a running round.
    task automatic test_reset();
        snap_t e, obs;
        drive_idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin
            errors++; $display("FAIL reset_por got %s want %s", fmt(obs), fmt(e));
        end
        @(negedge clk) rst = 1'b0;
        gif.Mode = 1'b0; gif.value = 7'd5; gif.state = 2'd2;
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            gif.word_done = (k == 2);
            gif.key_err   = (k == 3);
            exp_q.push_back(mk(0, time_secs(5, k), (k >= 2) ? 1 : 0, (k >= 3) ? 1 : 0, 0));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_prerun k=%0d got %s want %s", k, fmt(obs), fmt(e));
            end
        end
        gif.word_done = 1'b0; gif.key_err = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin
            errors++; $display("FAIL reset_async got %s want %s", fmt(obs), fmt(e));
        end
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            exp_q.push_back(mk(0, time_secs(5, k), 0, 0, 0));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_reload k=%0d got %s want %s", k, fmt(obs), fmt(e));
            end
        end
        gif.state = 2'd0;
        @(negedge clk);
        wpm_prev = 8'd0;
    endtask

    // Time mode, limit 3 s, five words during the round.
    task automatic test_time_mode();
        snap_t e, obs;
        int nw;
        nw = 0;
        gif.Mode = 1'b0; gif.value = 7'd3; gif.state = 2'd2;
        exp_q.push_back(mk(0, 3, 0, 0, wpm_prev));
        @(negedge clk);
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin
            errors++; $display("FAIL time_load got %s want %s", fmt(obs), fmt(e));
        end
        // Inputs after load must be ignored.
        gif.Mode = 1'b1; gif.value = 7'd50;
        for (int k = 1; k <= 16; k++) begin
            gif.word_done = (k == 2) || (k == 3) || (k == 5) || (k == 6) || (k == 9) || (k >= 13);
            if (gif.word_done && k <= 12) nw++;
            if (k < 12)
                exp_q.push_back(mk(0, time_secs(3, k), nw, 0, wpm_prev));
            else
                exp_q.push_back(mk(1, 0, 5, 0, WPM_EN ? 100 : 0));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL time_run k=%0d got %s want %s", k, fmt(obs), fmt(e));
            end
        end
        gif.word_done = 1'b0; gif.state = 2'd0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, 0, 5, 0, WPM_EN ? 100 : 0));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL time_idle k=%0d got %s want %s", k, fmt(obs), fmt(e));
            end
        end
        wpm_prev = WPM_EN ? 8'd100 : 8'd0;
    endtask

    // Word mode, target 2 words; then DONE held with state 3 and released with state 0.
    task automatic test_word_mode();
        snap_t e, obs;
        int ws;
        gif.Mode = 1'b1; gif.value = 7'd2; gif.state = 2'd2;
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            gif.word_done = (k == 6) || (k == 10) || (k == 12);
            gif.state     = (k >= 11) ? 2'd3 : 2'd2;
            ws = (k < 6) ? 0 : ((k < 10) ? 1 : 2);
            if (k < 10)
                exp_q.push_back(mk(0, k / 4, ws, 0, wpm_prev));
            else
                exp_q.push_back(mk(1, 2, 2, 0, WPM_EN ? 60 : 0));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL word_run k=%0d got %s want %s", k, fmt(obs), fmt(e));
            end
        end
        gif.word_done = 1'b0; gif.state = 2'd0;
        exp_q.push_back(mk(0, 2, 2, 0, WPM_EN ? 60 : 0));
        @(negedge clk);
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin
            errors++; $display("FAIL word_release got %s want %s", fmt(obs), fmt(e));
        end
        wpm_prev = WPM_EN ? 8'd60 : 8'd0;
    endtask

    // Tick, word and error in one cycle; then errs saturation under 300 pulses.
    task automatic test_simultaneous();
        snap_t e, obs;
        int ne;
        gif.Mode = 1'b1; gif.value = 7'd127; gif.state = 2'd2;
        @(negedge clk);
        for (int k = 1; k <= 304; k++) begin
            gif.word_done = (k == 4);
            gif.key_err   = (k >= 4);
            ne = (k < 4) ? 0 : (k - 3);
            if (ne > 255) ne = 255;
            exp_q.push_back(mk(0, k / 4, (k >= 4) ? 1 : 0, ne, wpm_prev));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL simul k=%0d got %s want %s", k, fmt(obs), fmt(e));
            end
        end
        gif.key_err = 1'b0; gif.word_done = 1'b0; gif.state = 2'd0;
        exp_q.push_back(mk(0, 76, 1, 255, wpm_prev));
        @(negedge clk);
        obs = sample(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin
            errors++; $display("FAIL simul_abort got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    // Leaving INGAME mid-round: finish stays low and counters freeze.
    task automatic test_abort();
        snap_t e, obs;
        gif.Mode = 1'b0; gif.value = 7'd10; gif.state = 2'd2;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            gif.state     = (k >= 7) ? 2'd0 : 2'd2;
            gif.word_done = (k == 2) || (k >= 8);
            gif.key_err   = (k == 3) || (k >= 8);
            if (k <= 6)
                exp_q.push_back(mk(0, time_secs(10, k), (k >= 2) ? 1 : 0, (k >= 3) ? 1 : 0, wpm_prev));
            else
                exp_q.push_back(mk(0, 9, 1, 1, wpm_prev));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL abort k=%0d got %s want %s", k, fmt(obs), fmt(e));
            end
        end
        gif.word_done = 1'b0; gif.key_err = 1'b0;
    endtask

    // Limit 0 in both modes finishes on the first RUN cycle; elapsed 0 counts as 1.
    task automatic test_zero_limit();
        snap_t e, obs;
        for (int m = 0; m < 2; m++) begin
            gif.Mode = m[0]; gif.value = 7'd0; gif.state = 2'd2;
            @(negedge clk);
            gif.word_done = m[0];
            if (m == 0)
                exp_q.push_back(mk(1, 0, 0, 0, 0));
            else
                exp_q.push_back(mk(1, 0, 1, 0, WPM_EN ? 60 : 0));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL zero_limit mode=%0d got %s want %s", m, fmt(obs), fmt(e));
            end
            gif.word_done = 1'b0; gif.state = 2'd0;
            exp_q.push_back(mk(0, 0, m, 0, (m == 1 && WPM_EN) ? 60 : 0));
            @(negedge clk);
            obs = sample(); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL zero_release mode=%0d got %s want %s", m, fmt(obs), fmt(e));
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wpm_prev = 8'd0;
        test_reset();
        test_time_mode();
        test_word_mode();
        test_simultaneous();
        test_abort();
        test_zero_limit();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
